// File: rtl/fifo_pkg.sv
// Shared defaults for the packet buffer SRAM.
// Latency: n/a (constants only).
// Backpressure: n/a.
package fifo_pkg;
    localparam int DWIDTH_DEF      = 72;
    localparam int IAWIDTH_DEF     = 10;
    localparam int ALMFULL_GAP_DEF = 4;
endpackage

// File: rtl/fifo_sram_dp.sv
// True dual-port RAM with registered read data on both ports.
// Latency: 1 cycle read; port A is write-first, port B reads old data.
// Backpressure: none; same-address writes resolve with port A winning.
module sram_dp #(
    parameter int DWIDTH  = 72,
    parameter int IAWIDTH = 10
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en_a,
    input  logic               we_a,
    input  logic [IAWIDTH-1:0] addr_a,
    input  logic [DWIDTH-1:0]  din_a,
    output logic [DWIDTH-1:0]  dout_a,
    input  logic               en_b,
    input  logic               we_b,
    input  logic [IAWIDTH-1:0] addr_b,
    input  logic [DWIDTH-1:0]  din_b,
    output logic [DWIDTH-1:0]  dout_b
);
    localparam int DEPTH = 2 ** IAWIDTH;

    logic [DWIDTH-1:0] mem [DEPTH];

    // Port A is written last so it overrides port B on an address clash.
    always_ff @(posedge clk) begin
        if (we_b) mem[addr_b] <= din_b;
        if (we_a) mem[addr_a] <= din_a;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dout_a <= '0;
            dout_b <= '0;
        end else begin
            if (en_a) dout_a <= we_a ? din_a : mem[addr_a];
            if (en_b) dout_b <= mem[addr_b];
        end
    end
endmodule

// File: rtl/fifo_sram.sv
// Packet buffer: circular FIFO when pc_en=0, processor-owned dual-port RAM when pc_en=1.
// Latency: pop data and port-A read data appear 1 cycle after the request.
// Backpressure: pushes when full are dropped; almfull leaves room for 4 in-flight pushes.
module fifo_sram
    import fifo_pkg::*;
#(
    parameter int DWIDTH      = DWIDTH_DEF,
    parameter int IAWIDTH     = IAWIDTH_DEF,
    parameter int ALMFULL_GAP = ALMFULL_GAP_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               pc_en,
    input  logic               wea,
    input  logic [IAWIDTH-1:0] addra,
    input  logic [DWIDTH-1:0]  dina,
    input  logic               web,
    input  logic [IAWIDTH-1:0] addrb,
    input  logic [DWIDTH-1:0]  dinb,
    input  logic [DWIDTH-1:0]  fifo_input,
    input  logic               reb,
    output logic [DWIDTH-1:0]  sram_data_out,
    output logic [DWIDTH-1:0]  fifo_output,
    output logic               almfull,
    output logic               fifo_empty,
    output logic               stall
);
    localparam int DEPTH = 2 ** IAWIDTH;
    localparam logic [IAWIDTH:0]   CNT_FULL = (IAWIDTH+1)'(DEPTH);
    localparam logic [IAWIDTH:0]   CNT_AF   = (IAWIDTH+1)'(DEPTH - ALMFULL_GAP);
    localparam logic [IAWIDTH:0]   CNT_ONE  = (IAWIDTH+1)'(1);
    localparam logic [IAWIDTH-1:0] PTR_ONE  = IAWIDTH'(1);

    logic [IAWIDTH-1:0] wr_ptr, rd_ptr;
    logic [IAWIDTH:0]   count, count_nxt;
    logic               push_ok, pop_ok;

    logic               en_a, we_a, en_b, we_b;
    logic [IAWIDTH-1:0] addr_a, addr_b;
    logic [DWIDTH-1:0]  din_a;

    // FIFO ops are gated by pc_en in the same cycle, so an op racing pc_en rising is lost.
    assign push_ok = !reset && !pc_en && wea && (count != CNT_FULL);
    assign pop_ok  = !reset && !pc_en && reb && (count != '0);
    assign stall   = pc_en;

    always_comb begin
        count_nxt = count;
        if (push_ok && !pop_ok)      count_nxt = count + CNT_ONE;
        else if (pop_ok && !push_ok) count_nxt = count - CNT_ONE;
    end

    assign en_a   = pc_en;
    assign we_a   = !reset && (pc_en ? wea : push_ok);
    assign addr_a = pc_en ? addra : wr_ptr;
    assign din_a  = pc_en ? dina : fifo_input;
    assign en_b   = pop_ok;
    assign we_b   = !reset && pc_en && web;
    assign addr_b = pc_en ? addrb : rd_ptr;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            fifo_empty <= 1'b1;
            almfull    <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop_ok)  rd_ptr <= rd_ptr + PTR_ONE;
            count      <= count_nxt;
            fifo_empty <= (count_nxt == '0);
            almfull    <= (count_nxt >= CNT_AF);
        end
    end

    sram_dp #(
        .DWIDTH  (DWIDTH),
        .IAWIDTH (IAWIDTH)
    ) u_ram (
        .clk    (clk),
        .reset  (reset),
        .en_a   (en_a),
        .we_a   (we_a),
        .addr_a (addr_a),
        .din_a  (din_a),
        .dout_a (sram_data_out),
        .en_b   (en_b),
        .we_b   (we_b),
        .addr_b (addr_b),
        .din_b  (dinb),
        .dout_b (fifo_output)
    );
endmodule

// File: tb/tb_fifo_sram.sv
// Self-checking bench for fifo_sram: vector table, queue-model random run, corner sequences.
module tb_fifo_sram;
    logic        clk = 1'b0;
    logic        reset, pc_en, wea, web, reb;
    logic [9:0]  addra, addrb;
    logic [71:0] dina, dinb, fifo_input;
    logic [71:0] sram_data_out, fifo_output;
    logic        almfull, fifo_empty, stall;

    int errors = 0;
    int checks = 0;

    fifo_sram dut (
        .clk           (clk),
        .reset         (reset),
        .pc_en         (pc_en),
        .wea           (wea),
        .addra         (addra),
        .dina          (dina),
        .web           (web),
        .addrb         (addrb),
        .dinb          (dinb),
        .fifo_input    (fifo_input),
        .reb           (reb),
        .sram_data_out (sram_data_out),
        .fifo_output   (fifo_output),
        .almfull       (almfull),
        .fifo_empty    (fifo_empty),
        .stall         (stall)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wea;
        logic        reb;
        logic [71:0] din;
        logic [71:0] exp_out;
        logic        exp_empty;
    } vec_t;

    vec_t        vecs [11];
    logic [71:0] q [$];
    logic [71:0] exp_out;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_empty"}, 72'(fifo_empty), 72'd1);
        chk({tag, "_almfull"}, 72'(almfull), 72'd0);
        chk({tag, "_fifo_output"}, fifo_output, 72'd0);
        chk({tag, "_sram_data_out"}, sram_data_out, 72'd0);
    endtask

    initial begin
        reset = 1'b1; pc_en = 1'b0; wea = 1'b0; web = 1'b0; reb = 1'b0;
        addra = '0; addrb = '0; dina = '0; dinb = '0; fifo_input = '0;

        // Table: reb on empty, push 0..2, pop 3x, pop on empty, push+pop corner cases.
        vecs[0]  = '{1'b0, 1'b1, 72'd0,  72'd0,  1'b1};
        vecs[1]  = '{1'b1, 1'b0, 72'd0,  72'd0,  1'b0};
        vecs[2]  = '{1'b1, 1'b0, 72'd1,  72'd0,  1'b0};
        vecs[3]  = '{1'b1, 1'b0, 72'd2,  72'd0,  1'b0};
        vecs[4]  = '{1'b0, 1'b1, 72'd0,  72'd0,  1'b0};
        vecs[5]  = '{1'b0, 1'b1, 72'd0,  72'd1,  1'b0};
        vecs[6]  = '{1'b0, 1'b1, 72'd0,  72'd2,  1'b1};
        vecs[7]  = '{1'b0, 1'b1, 72'd0,  72'd2,  1'b1};
        vecs[8]  = '{1'b1, 1'b1, 72'h77, 72'd2,  1'b0};
        vecs[9]  = '{1'b1, 1'b1, 72'h88, 72'h77, 1'b0};
        vecs[10] = '{1'b0, 1'b1, 72'd0,  72'h88, 1'b1};

        repeat (10) tick();
        check_reset_state("reset_held");
        chk("reset_stall", 72'(stall), 72'd0);
        reset = 1'b0;
        tick();
        check_reset_state("after_release");

        for (int i = 0; i < 11; i++) begin
            wea = vecs[i].wea; reb = vecs[i].reb; fifo_input = vecs[i].din;
            tick();
            wea = 1'b0; reb = 1'b0;
            chk($sformatf("vec%0d_out", i), fifo_output, vecs[i].exp_out);
            chk($sformatf("vec%0d_empty", i), 72'(fifo_empty), 72'(vecs[i].exp_empty));
            chk($sformatf("vec%0d_almfull", i), 72'(almfull), 72'd0);
        end

        // Random traffic against a queue model; pushes honour almfull of the model.
        reset = 1'b1; tick(); reset = 1'b0;
        check_reset_state("rand_reset");
        q.delete();
        exp_out = '0;
        begin
            int cnt = 0;
            for (int cyc = 0; cyc < 3000; cyc++) begin
                logic push_req, pop_req, pop_go;
                push_req = (q.size() < 1020) && ($urandom_range(0, 3) != 0);
                pop_req  = (cyc % 2 == 1) && ($urandom_range(0, 1) == 1);
                wea = push_req; reb = pop_req; fifo_input = 72'(cnt);
                pop_go = pop_req && (q.size() > 0);
                if (pop_go) exp_out = q.pop_front();
                if (push_req && q.size() < 1024) begin
                    q.push_back(72'(cnt));
                    cnt++;
                end
                tick();
                chk("rand_out", fifo_output, exp_out);
                chk("rand_empty", 72'(fifo_empty), 72'(q.size() == 0));
                chk("rand_almfull", 72'(almfull), 72'(q.size() >= 1020));
            end
        end

        // Reset mid-stream with ops in flight.
        wea = 1'b1; reb = 1'b1; reset = 1'b1;
        tick();
        reset = 1'b0; wea = 1'b0; reb = 1'b0;
        check_reset_state("midstream_reset");

        // Fill to almfull, to full, drop an extra push, then drain.
        for (int i = 0; i < 1024; i++) begin
            wea = 1'b1; fifo_input = 72'(i);
            tick();
            if (i == 1018) chk("almfull_at_1019", 72'(almfull), 72'd0);
            if (i == 1019) chk("almfull_at_1020", 72'(almfull), 72'd1);
        end
        wea = 1'b1; fifo_input = 72'hDEAD;
        tick();
        wea = 1'b0;
        chk("full_almfull", 72'(almfull), 72'd1);
        chk("full_empty", 72'(fifo_empty), 72'd0);
        for (int i = 0; i < 1024; i++) begin
            reb = 1'b1;
            tick();
            chk($sformatf("drain%0d", i), fifo_output, 72'(i));
        end
        reb = 1'b1;
        tick();
        reb = 1'b0;
        chk("drained_empty", 72'(fifo_empty), 72'd1);
        chk("drained_almfull", 72'(almfull), 72'd0);
        chk("pop_empty_holds", fifo_output, 72'd1023);

        // Processor-mode in-place edit of buffered words (rd_ptr is 0 here).
        for (int i = 0; i < 5; i++) begin
            wea = 1'b1; fifo_input = 72'(100 + i);
            tick();
        end
        pc_en = 1'b1; wea = 1'b1; addra = 10'd1; dina = 72'hAB;
        reb = 1'b1; fifo_input = 72'd999;
        tick();
        chk("pc_stall", 72'(stall), 72'd1);
        chk("pc_write_read_a", sram_data_out, 72'hAB);
        chk("pc_reb_discarded", fifo_output, 72'd1023);
        wea = 1'b0; reb = 1'b0; web = 1'b1; addrb = 10'd2; dinb = 72'hCD;
        tick();
        chk("pc_read_a_hold", sram_data_out, 72'hAB);
        wea = 1'b1; addra = 10'd3; dina = 72'h11; web = 1'b1; addrb = 10'd3; dinb = 72'h22;
        tick();
        wea = 1'b0; web = 1'b0;
        tick();
        chk("pc_a_wins", sram_data_out, 72'h11);
        addra = 10'd0;
        tick();
        chk("pc_word0_intact", sram_data_out, 72'd100);
        pc_en = 1'b0;
        begin
            logic [71:0] exp_seq [5];
            exp_seq[0] = 72'd100; exp_seq[1] = 72'hAB; exp_seq[2] = 72'hCD;
            exp_seq[3] = 72'h11;  exp_seq[4] = 72'd104;
            for (int i = 0; i < 5; i++) begin
                reb = 1'b1;
                tick();
                chk($sformatf("edit_pop%0d", i), fifo_output, exp_seq[i]);
            end
        end
        reb = 1'b0;
        chk("edit_stall_low", 72'(stall), 72'd0);
        chk("edit_empty", 72'(fifo_empty), 72'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
